// File: rtl/softmax_stream_unit.sv
// -----------------------------------------------------------------------------
// softmax_stream_unit
//
// Streaming base-2 softmax engine. A vector of 1..MAX_LEN signed fixed-point
// logits (already scaled by log2(e) upstream) is buffered, then processed in
// three passes:
//   EXP : e_i = 2^(x_i - max) in unsigned Q1.FRAC_W, written back in place,
//         while the running sum is accumulated.
//   DIV : q_i = floor(e_i * 2^(OUT_W-1) / sum) by a restoring divider
//         (one dividend-load cycle plus OUT_W iteration cycles).
//   OUT : q_i is presented on the output stream until accepted.
// Only one vector is in flight; input is stalled (s_ready=0) outside LOAD.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   s_valid/s_ready   input element handshake
//   s_data            signed logit, Q(DATA_W-FRAC_W).FRAC_W
//   s_last            marks the final element of a vector
//   m_valid/m_ready   output probability handshake
//   m_data            probability, unsigned Q1.(OUT_W-1)
//   m_last            marks the final probability of a vector
//   busy              high whenever the unit is not accepting input
//   len_err           vector was cut at MAX_LEN without s_last
// -----------------------------------------------------------------------------
module softmax_stream_unit #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int OUT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_last,
  output logic              busy,
  output logic              len_err
);

  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int EXP_W  = FRAC_W + 1;           // Q1.FRAC_W exp value
  localparam int SUM_W  = FRAC_W + 1 + LEN_W;   // sum of up to MAX_LEN exps
  localparam int M_W    = DATA_W + 1;           // max - x, never negative
  localparam int K_W    = M_W - FRAC_W;         // integer part of max - x
  localparam int NUM_W  = FRAC_W + 2;           // holds 2^(FRAC_W+1)
  localparam int DC_W   = $clog2(OUT_W + 1);

  localparam logic [NUM_W-1:0] NUM_TOP = NUM_W'(2 ** (FRAC_W + 1));
  localparam logic [OUT_W-1:0] Q_ONE   = {1'b1, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {ST_LOAD, ST_EXP, ST_DIV, ST_OUT} state_e;

  state_e state_q, state_d;

  // Element buffer: holds logits during LOAD, exp values after EXP.
  logic [DATA_W-1:0] mem_q [MAX_LEN];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         idx_q, idx_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic [SUM_W-1:0]         sum_q, sum_d;
  logic [SUM_W-1:0]         rem_q, rem_d;
  logic [OUT_W-1:0]         quo_q, quo_d;
  logic [DC_W-1:0]          div_cnt_q, div_cnt_d;
  logic                     len_err_q, len_err_d;

  // Control terms shared by the next-state and datapath logic.
  logic in_fire, out_fire, at_max, load_end, idx_last, div_done;

  assign in_fire  = s_valid && (state_q == ST_LOAD);
  assign out_fire = m_ready && (state_q == ST_OUT);
  assign at_max   = (cnt_q == LEN_W'(MAX_LEN - 1));
  assign load_end = in_fire && (s_last || at_max);
  assign idx_last = (idx_q == len_q - LEN_W'(1));
  assign div_done = (div_cnt_q == DC_W'(OUT_W));

  // Buffer read port, shared by EXP (logit) and DIV (exp value).
  logic [DATA_W-1:0] cur;
  logic [EXP_W-1:0]  rd_exp;

  assign cur    = mem_q[idx_q[ADDR_W-1:0]];
  assign rd_exp = cur[EXP_W-1:0];

  // 2^-(max - x): split into integer k and fraction f, approximate
  // 2^-f by the linear term (2 - f), then shift by k+1.
  logic [M_W-1:0]    m_diff;
  logic [K_W-1:0]    k_int;
  logic [FRAC_W-1:0] f_frac;
  logic [NUM_W-1:0]  num;
  logic [EXP_W-1:0]  exp_val;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    m_diff = {max_q[DATA_W-1], max_q} - {cur[DATA_W-1], cur};
    k_int  = m_diff[M_W-1:FRAC_W];
    f_frac = m_diff[FRAC_W-1:0];
    num    = NUM_TOP - {2'b00, f_frac};
    exp_val = '0;
    // Shifts of FRAC_W+2 or more would clear every bit anyway.
    if (k_int < K_W'(FRAC_W + 1)) begin
      exp_val = EXP_W'(num >> (k_int + K_W'(1)));
    end
  end

  // One restoring-division step: shift the next dividend bit (MSB of the
  // quotient shift register) into the partial remainder.
  logic [SUM_W:0]   trial;
  logic             trial_ge;
  logic [SUM_W-1:0] rem_step;
  logic [OUT_W-1:0] q_sat;

  always_comb begin
    trial    = {rem_q, quo_q[OUT_W-1]};
    trial_ge = (trial >= {1'b0, sum_q});
    rem_step = trial_ge ? SUM_W'(trial - {1'b0, sum_q}) : trial[SUM_W-1:0];
    q_sat    = (quo_q > Q_ONE) ? Q_ONE : quo_q;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_LOAD;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD: if (load_end) state_d = ST_EXP;
      ST_EXP:  if (idx_last) state_d = ST_DIV;
      ST_DIV:  if (div_done) state_d = ST_OUT;
      ST_OUT:  if (out_fire) state_d = idx_last ? ST_LOAD : ST_DIV;
      default: state_d = ST_LOAD;
    endcase
  end

  // FSM: outputs
  always_comb begin
    s_ready = (state_q == ST_LOAD);
    busy    = (state_q != ST_LOAD);
    m_valid = (state_q == ST_OUT);
    m_data  = m_valid ? q_sat : '0;
    m_last  = m_valid && idx_last;
    len_err = len_err_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d     = cnt_q;
    len_d     = len_q;
    idx_d     = idx_q;
    max_d     = max_q;
    sum_d     = sum_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_cnt_d = div_cnt_q;
    len_err_d = len_err_q;
    mem_we    = 1'b0;
    mem_waddr = idx_q[ADDR_W-1:0];
    mem_wdata = '0;

    unique case (state_q)
      ST_LOAD: begin
        if (in_fire) begin
          mem_we    = 1'b1;
          mem_waddr = cnt_q[ADDR_W-1:0];
          mem_wdata = s_data;
          cnt_d     = cnt_q + LEN_W'(1);
          if (cnt_q == '0) begin
            max_d     = $signed(s_data);
            len_err_d = 1'b0;
          end else if ($signed(s_data) > max_q) begin
            max_d = $signed(s_data);
          end
          if (load_end) begin
            len_d     = cnt_q + LEN_W'(1);
            idx_d     = '0;
            sum_d     = '0;
            // Ending without s_last means the MAX_LEN cut-off was hit.
            len_err_d = !s_last;
          end
        end
      end

      ST_EXP: begin
        mem_we    = 1'b1;
        mem_wdata = DATA_W'(exp_val);
        sum_d     = sum_q + SUM_W'(exp_val);
        if (idx_last) begin
          idx_d     = '0;
          div_cnt_d = '0;
        end else begin
          idx_d = idx_q + LEN_W'(1);
        end
      end

      ST_DIV: begin
        if (div_cnt_q == '0) begin
          // Dividend is e << (OUT_W-1). Its bits above the low OUT_W are
          // e >> 1, which is always below sum, so they seed the remainder
          // and OUT_W steps produce the full quotient.
          rem_d = SUM_W'(rd_exp >> 1);
          quo_d = {rd_exp[0], {(OUT_W - 1){1'b0}}};
        end else begin
          rem_d = rem_step;
          quo_d = {quo_q[OUT_W-2:0], trial_ge};
        end
        div_cnt_d = div_cnt_q + DC_W'(1);
      end

      ST_OUT: begin
        if (out_fire) begin
          div_cnt_d = '0;
          if (idx_last) begin
            cnt_d = '0;
            sum_d = '0;
            idx_d = '0;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      max_q     <= '0;
      sum_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_cnt_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      max_q     <= max_d;
      sum_q     <= sum_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_cnt_q <= div_cnt_d;
      len_err_q <= len_err_d;
    end
  end

  // NOTE: the buffer is not reset; every entry is written in LOAD before it
  // is read, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

endmodule

// File: doc/softmax_stream_unit.md
Name: softmax_stream_unit

Overview:
- Streaming fixed-point softmax engine for the AI accelerator path.
- Accepts a vector of 1..MAX_LEN signed fixed-point logits over a valid/ready stream and buffers them internally.
- Computes base-2 softmax in three sequential passes: max search, exp/sum, normalise by iterative division.
- Emits one probability per element on a valid/ready output stream; upstream pre-scales logits by log2(e).

Parameters:
- DATA_W, 16: input logit width, signed Q(DATA_W-FRAC_W).FRAC_W.
- FRAC_W, 8: input fractional bits; exp values are unsigned Q1.FRAC_W (FRAC_W+1 bits).
- MAX_LEN, 64: maximum vector length; also the buffer depth.
- LEN_W, $clog2(MAX_LEN+1): element counter width.
- OUT_W, 16: output width, unsigned Q1.(OUT_W-1), so 1.0 = 2^(OUT_W-1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- s_valid  in  1  input element valid
- s_ready  out  1  input element accept
- s_data  in  DATA_W  signed logit
- s_last  in  1  final element of vector
- m_valid  out  1  output probability valid
- m_ready  in  1  downstream accept
- m_data  out  OUT_W  probability
- m_last  out  1  final output of vector
- busy  out  1  high in any state other than LOAD
- len_err  out  1  vector truncated at MAX_LEN

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n).
- Reset: state=LOAD, s_ready=1, m_valid=0, m_data=0, m_last=0, busy=0, len_err=0, counters/max/sum=0.
- Reset mid-operation discards any partial or in-flight vector; next cycle is LOAD.
- Handshake: a transfer occurs when valid&&ready on a rising edge. m_data and m_last hold stable while m_valid=1 && m_ready=0.
- LOAD:
  - s_ready=1.
  - Each accepted element is written to buf[cnt] and cnt increments.
  - The first element of a vector initialises max; later elements update max on signed compare (x>max).
  - len_err clears on the first accept of a new vector.
  - Accepting an element with s_last=1, or accepting the MAX_LEN-th element, ends the vector. For the MAX_LEN-th element without s_last, set len_err=1 (held until next vector starts).
  - Then len=cnt, go to EXP.
- EXP, one element per cycle for idx 0..len-1:
  - m = max - buf[idx] (unsigned, DATA_W+1 bits).
  - k = m>>FRAC_W; f = m[FRAC_W-1:0].
  - e = (2^(FRAC_W+1) - f) >> (k+1), forced to 0 when k+1 >= FRAC_W+2.
  - Write e back to buf[idx]; sum += e (SUM_W = FRAC_W+1+LEN_W, never overflows).
  - After len cycles go to DIV with idx=0.
- DIV:
  - Restoring divide q = floor((buf[idx] << (OUT_W-1)) / sum), OUT_W cycles.
  - Result saturates to 2^(OUT_W-1).
  - sum >= 2^FRAC_W always, because the max element gives e=1.0, so there is no divide-by-zero.
- OUT:
  - m_valid=1, m_data=q, m_last=(idx==len-1).
  - On handshake: if not last, idx++ and go to DIV; if last, clear cnt and sum and go to LOAD.
- Latency:
  - Last input accepted at edge T.
  - EXP occupies cycles T+1..T+len.
  - First m_valid rises at T+len+OUT_W+1.
  - Each subsequent element follows OUT_W+1 cycles after the previous handshake.
- s_ready=0 in EXP, DIV and OUT; there is no overlap between vectors.
- Any s_valid/s_last while s_ready=0 is ignored.

Test Plan:
(All values with DATA_W=16, FRAC_W=8, OUT_W=16, MAX_LEN=64.)
- Single element 0x1234 with s_last -> one output 0x8000, m_last=1; m_valid rises exactly 1+1+16 cycles after accept; len_err=0.
- Vector {0x0100, 0x0100} -> e=256 each, sum=512 -> outputs 0x4000, 0x4000; m_last only on the second.
- Vector {0x0000, 0xFF00} -> e={256,128}, sum=384 -> outputs 0x5555, 0x2AAA.
- Vector {0x7F00, 0x8000} -> m=0xFF00 for the second, so e=0 -> outputs 0x8000, 0x0000.
- 64 elements of 0x0000, s_last never asserted -> s_ready drops after the 64th; len_err=1; 64 outputs of 0x0200; last has m_last=1; len_err clears on the next vector's first accept.
- Backpressure and reset:
  - Hold m_ready=0 for 10 cycles during OUT -> m_data and m_last stable, no loss or duplication.
  - Drive rst_n=0 for one cycle mid-DIV -> next cycle m_valid=0, s_ready=1, busy=0; a fresh vector then produces correct results.
